// File: rtl/serial_paralelo_align_if.sv
// Lane-side signal bundle for the receive serial-to-parallel aligner.
// The slave modport is the aligner itself; master is whoever feeds bits and consumes bytes.
interface serial_paralelo_align_if;
   logic       data_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       byte_strobe;
   logic       active;

   modport master (
      output data_in,
      input  data_out,
      input  valid_out,
      input  byte_strobe,
      input  active
   );

   modport slave (
      input  data_in,
      output data_out,
      output valid_out,
      output byte_strobe,
      output active
   );
endinterface

// File: rtl/serial_paralelo_align.sv
// One-lane receive deserializer: hunts for COM symbols in the bit stream, locks byte
// alignment after COM_NEEDED consecutive aligned COMs, then emits one byte per 8 bit clocks.
module serial_paralelo_align #(
   parameter logic [7:0] COM_SYMBOL = 8'hBC,
   parameter int         COM_NEEDED = 4
) (
   input  logic                    clk_32f,
   input  logic                    reset,
   serial_paralelo_align_if.slave  lane
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      ALIGN  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_CNT = 4'(COM_NEEDED - 1);

   state_t     state_reg, state_next;
   logic [7:0] sr_reg, sr_next;
   logic [2:0] bit_cnt_reg, bit_cnt_next;
   logic [3:0] com_cnt_reg, com_cnt_next;
   logic [7:0] data_out_reg, data_out_next;
   logic       valid_out_reg, valid_out_next;
   logic       byte_strobe_reg, byte_strobe_next;
   logic       active_reg, active_next;

   logic is_com;
   logic boundary;

   assign is_com   = (sr_reg == COM_SYMBOL);
   assign boundary = (bit_cnt_reg == 3'd0);

   always_comb begin
      state_next       = state_reg;
      sr_next          = {sr_reg[6:0], lane.data_in};
      bit_cnt_next     = bit_cnt_reg;
      com_cnt_next     = com_cnt_reg;
      data_out_next    = data_out_reg;
      valid_out_next   = 1'b0;
      byte_strobe_next = 1'b0;

      case (state_reg)
         HUNT: begin
            bit_cnt_next = 3'd0;
            // The bit entering sr on the transition edge is already bit 1 of the next byte.
            if (is_com) begin
               state_next   = ALIGN;
               com_cnt_next = 4'd1;
               bit_cnt_next = 3'd1;
            end
         end
         ALIGN: begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (boundary) begin
               if (is_com) begin
                  if (com_cnt_reg == LOCK_CNT) begin
                     state_next   = ACTIVE;
                     com_cnt_next = 4'd0;
                  end else begin
                     com_cnt_next = com_cnt_reg + 4'd1;
                  end
               end else begin
                  // This cycle's sr is not re-examined; hunting resumes on the next bit.
                  state_next   = HUNT;
                  com_cnt_next = 4'd0;
                  bit_cnt_next = 3'd0;
               end
            end
         end
         ACTIVE: begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (boundary) begin
               byte_strobe_next = 1'b1;
               if (!is_com) begin
                  data_out_next  = sr_reg;
                  valid_out_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = HUNT;
         end
      endcase

      active_next = (state_next == ACTIVE);
   end

   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         state_reg       <= HUNT;
         sr_reg          <= 8'h00;
         bit_cnt_reg     <= 3'd0;
         com_cnt_reg     <= 4'd0;
         data_out_reg    <= 8'h00;
         valid_out_reg   <= 1'b0;
         byte_strobe_reg <= 1'b0;
         active_reg      <= 1'b0;
      end else begin
         state_reg       <= state_next;
         sr_reg          <= sr_next;
         bit_cnt_reg     <= bit_cnt_next;
         com_cnt_reg     <= com_cnt_next;
         data_out_reg    <= data_out_next;
         valid_out_reg   <= valid_out_next;
         byte_strobe_reg <= byte_strobe_next;
         active_reg      <= active_next;
      end
   end

   assign lane.data_out    = data_out_reg;
   assign lane.valid_out   = valid_out_reg;
   assign lane.byte_strobe = byte_strobe_reg;
   assign lane.active      = active_reg;

endmodule

// File: tb/tb_serial_paralelo_align.sv
// Scoreboard bench for serial_paralelo_align: a bit-stream reference model predicts lock
// time and every strobed byte; a monitor compares DUT outputs once per bit clock.
module tb_serial_paralelo_align;

   localparam logic [7:0] COM  = 8'hBC;
   localparam int         NEED = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   serial_paralelo_align_if lane_if ();

   serial_paralelo_align #(
      .COM_SYMBOL (COM),
      .COM_NEEDED (NEED)
   ) dut (
      .clk_32f (clk),
      .reset   (reset),
      .lane    (lane_if)
   );

   typedef struct {
      int         edge_no;
      logic       valid;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   logic bits[$];
   int   exp_active_edge;
   int   drv_idx;
   bit   running;
   int   tests;
   int   fails;
   exp_t mon_e;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
   endtask

   function automatic logic [7:0] rand_data();
      logic [7:0] r;
      do r = 8'($urandom_range(0, 255)); while (r == COM);
      return r;
   endfunction

   function automatic logic [7:0] window(input int p);
      logic [7:0] w;
      w = 8'h00;
      for (int j = 0; j < 8; j++) w = {w[6:0], bits[p - 7 + j]};
      return w;
   endfunction

   // Reference: walk the stream by bit position. Edge k shifts bits[k]; a byte ending at
   // position p is judged at edge p+1, which is where lock or a strobe becomes visible.
   task automatic model();
      int         n, pos, cnt, lock;
      bit         hunting;
      logic [7:0] w, last;
      exp_t       e;
      n = bits.size();
      exp_active_edge = -1;
      lock = -1;
      cnt = 0;
      pos = 7;
      hunting = 1'b1;
      while (pos < n && lock < 0) begin
         w = window(pos);
         if (hunting) begin
            if (w == COM) begin
               cnt = 1;
               hunting = 1'b0;
               pos += 8;
            end else begin
               pos += 1;
            end
         end else if (w == COM) begin
            cnt++;
            if (cnt == NEED) lock = pos;
            else pos += 8;
         end else begin
            hunting = 1'b1;
            cnt = 0;
            pos += 1;
         end
      end
      if (lock >= 0 && lock + 1 <= n - 1) begin
         exp_active_edge = lock + 1;
         last = 8'h00;
         for (int p = lock + 8; p + 1 <= n - 1; p += 8) begin
            w = window(p);
            e.edge_no = p + 1;
            e.valid = (w != COM);
            if (w != COM) last = w;
            e.data = last;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic run_bits(input string tag);
      bits.push_back(1'b0);
      bits.push_back(1'b0);
      model();
      for (int k = 0; k < bits.size(); k++) begin
         @(negedge clk);
         lane_if.data_in = bits[k];
         drv_idx = k;
         running = 1'b1;
      end
      @(negedge clk);
      running = 1'b0;
      check($sformatf("%s_all_strobes_seen", tag), exp_q.size(), 0);
      $display("[TB] scenario %s: %0d bits, lock edge %0d", tag, bits.size(), exp_active_edge);
      exp_q.delete();
      bits.delete();
   endtask

   // Reset lands mid-cycle so the clear must happen without a clock edge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2;
      reset = 1'b1;
      lane_if.data_in = 1'b0;
      #1;
      check($sformatf("%s_rst_active", tag), int'(lane_if.active), 0);
      check($sformatf("%s_rst_data", tag), int'(lane_if.data_out), 0);
      check($sformatf("%s_rst_valid", tag), int'(lane_if.valid_out), 0);
      check($sformatf("%s_rst_strobe", tag), int'(lane_if.byte_strobe), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      if (running) begin
         check($sformatf("active@%0d", drv_idx), int'(lane_if.active),
               int'(exp_active_edge >= 0 && drv_idx >= exp_active_edge));
         if (!(exp_active_edge >= 0 && drv_idx >= exp_active_edge))
            check($sformatf("idle_data@%0d", drv_idx), int'(lane_if.data_out), 0);
         if (lane_if.byte_strobe) begin
            if (exp_q.size() == 0) begin
               check($sformatf("unexpected_strobe@%0d", drv_idx), 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check($sformatf("strobe_edge@%0d", drv_idx), drv_idx, mon_e.edge_no);
               check($sformatf("valid@%0d", drv_idx), int'(lane_if.valid_out), int'(mon_e.valid));
               check($sformatf("data@%0d", drv_idx), int'(lane_if.data_out), int'(mon_e.data));
            end
         end else begin
            check($sformatf("valid_no_strobe@%0d", drv_idx), int'(lane_if.valid_out), 0);
         end
      end
   end

   initial begin
      tests = 0;
      fails = 0;
      running = 1'b0;
      drv_idx = -1;
      exp_active_edge = -1;
      lane_if.data_in = 1'b0;
      reset = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      check("por_active", int'(lane_if.active), 0);
      check("por_data", int'(lane_if.data_out), 0);
      check("por_valid", int'(lane_if.valid_out), 0);
      check("por_strobe", int'(lane_if.byte_strobe), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Alignment at bit offset 3.
      bits.push_back(1'b1);
      bits.push_back(1'b0);
      bits.push_back(1'b1);
      for (int i = 0; i < 4; i++) push_byte(COM);
      push_byte(8'hA5);
      for (int i = 0; i < 3; i++) push_byte(rand_data());
      run_bits("offset3");
      do_reset("offset3");

      // Broken COM run.
      push_byte(COM);
      push_byte(COM);
      push_byte(8'h00);
      for (int i = 0; i < 4; i++) push_byte(COM);
      push_byte(8'h3C);
      push_byte(rand_data());
      run_bits("broken");
      do_reset("broken");

      // Idle fill, followed by reset mid-byte while active.
      for (int i = 0; i < 4; i++) push_byte(COM);
      push_byte(8'h11);
      push_byte(COM);
      push_byte(8'h22);
      run_bits("idle_fill");
      do_reset("midstream");

      // Only three COMs after reset: lock must not happen.
      for (int i = 0; i < 3; i++) push_byte(COM);
      push_byte(8'h55);
      push_byte(8'h66);
      run_bits("relock_short");
      do_reset("relock_short");

      // COM pattern straddling 0B,C0; low-nibble fill cannot form another COM.
      push_byte(8'h0B);
      push_byte(8'hC0);
      for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(0, 15)));
      run_bits("straddle");
      do_reset("straddle");

      // Loopback-style traffic: random phase, lock preamble, 32-bit words MSB first with idle COMs.
      for (int t = 0; t < 20; t++) begin
         logic [31:0] word;
         int          pre;
         pre = $urandom_range(0, 7);
         for (int i = 0; i < pre; i++) bits.push_back(1'($urandom_range(0, 1)));
         for (int i = 0; i < 4; i++) push_byte(COM);
         for (int w = 0; w < 4; w++) begin
            word = {rand_data(), rand_data(), rand_data(), rand_data()};
            for (int b = 3; b >= 0; b--) begin
               push_byte(word[b*8 +: 8]);
               if ($urandom_range(0, 3) == 0) push_byte(COM);
            end
         end
         run_bits($sformatf("loop%0d", t));
         do_reset($sformatf("loop%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
